// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: opcodes, FSM
// state encoding, ALU op codes, datapath select encodings, trap causes and
// the Moore output decode used by the sequencer.
package mips_ctrl_pkg;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Sequencer states; exported unchanged on the debug state output
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_I    = 4'd3,
    S_ALU_WB    = 4'd4,
    S_MEM_ADDR  = 4'd5,
    S_MEM_READ  = 4'd6,
    S_MEM_WB    = 4'd7,
    S_MEM_WRITE = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_TRAP      = 4'd11
  } state_e;

  // ALU operation codes
  localparam logic [2:0] ALUOP_LUI    = 3'b000;
  localparam logic [2:0] ALUOP_SUB    = 3'b001;
  localparam logic [2:0] ALUOP_NOP    = 3'b010;
  localparam logic [2:0] ALUOP_ADD    = 3'b011;
  localparam logic [2:0] ALUOP_ADDI   = 3'b100;
  localparam logic [2:0] ALUOP_OR     = 3'b101;
  localparam logic [2:0] ALUOP_AND    = 3'b110;
  localparam logic [2:0] ALUOP_RFUNCT = 3'b111;

  // Register destination select
  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  // Write-back data select
  localparam logic [1:0] MEMTOREG_ALU = 2'b00;
  localparam logic [1:0] MEMTOREG_MDR = 2'b01;
  localparam logic [1:0] MEMTOREG_PC  = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Trap causes
  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

  // Registered Moore control word (strobes gated by in_MemReady are added
  // combinationally in the top level and are not part of this word)
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_type;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_to_reg;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       retire;
  } ctrl_t;

  // Control word for state s. op is the IR opcode (valid from DECODE on);
  // from_r tells ALU_WB whether it was reached from EXEC_R.
  function automatic ctrl_t ctrl_decode(input state_e s, input logic [5:0] op,
                                        input logic from_r);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMM_SH2;
        c.alu_op    = ALUOP_ADD;
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RT;
        c.alu_op    = ALUOP_RFUNCT;
      end
      S_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        case (op)
          OP_ORI:  c.alu_op = ALUOP_OR;
          OP_ANDI: c.alu_op = ALUOP_AND;
          OP_LUI:  c.alu_op = ALUOP_LUI;
          default: c.alu_op = ALUOP_ADDI;
        endcase
      end
      S_ALU_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = MEMTOREG_ALU;
        c.reg_dst    = from_r ? REGDST_RD : REGDST_RT;
        c.retire     = 1'b1;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = MEMTOREG_MDR;
        c.reg_dst    = REGDST_RT;
        c.retire     = 1'b1;
      end
      S_MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_RT;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
        c.branch_type   = (op == OP_BEQ);
        c.retire        = 1'b1;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
        c.alu_op    = ALUOP_NOP;
        c.retire    = 1'b1;
        if (op == OP_JAL) begin
          c.reg_write  = 1'b1;
          c.reg_dst    = REGDST_RA;
          c.mem_to_reg = MEMTOREG_PC;
        end
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multi-cycle sequencer (master) and the MIPS
// datapath/memory (slave).
//
// Memory handshake: the master holds MemRead or MemWrite (with IorD) steady
// for as long as it stays in a memory state. in_MemReady is a completion
// strobe: the cycle in which it is 1 completes the pending access and the
// master moves on at the next edge. in_MemReady has no meaning outside the
// memory states and is ignored there.
interface mips_multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       in_OP_6;
  logic             in_MemReady;
  logic             o_PCWrite;
  logic             o_PCWriteCond;
  logic             o_BranchType;
  logic             o_IorD;
  logic             o_MemRead;
  logic             o_MemWrite;
  logic             o_IRWrite;
  logic [1:0]       o_MemtoReg_2;
  logic [1:0]       o_RegDst_2;
  logic             o_RegWrite;
  logic             o_ALUSrcA;
  logic [1:0]       o_ALUSrcB_2;
  logic [1:0]       o_PCSource_2;
  logic [2:0]       o_ALUOp_3;
  logic             o_Retired;
  logic [CNT_W-1:0] o_InstrCount;
  logic             o_Trap;
  logic [1:0]       o_TrapCause_2;
  logic [3:0]       o_State_4;

  modport master (
    input  in_OP_6, in_MemReady,
    output o_PCWrite, o_PCWriteCond, o_BranchType, o_IorD, o_MemRead,
           o_MemWrite, o_IRWrite, o_MemtoReg_2, o_RegDst_2, o_RegWrite,
           o_ALUSrcA, o_ALUSrcB_2, o_PCSource_2, o_ALUOp_3, o_Retired,
           o_InstrCount, o_Trap, o_TrapCause_2, o_State_4
  );

  modport slave (
    output in_OP_6, in_MemReady,
    input  o_PCWrite, o_PCWriteCond, o_BranchType, o_IorD, o_MemRead,
           o_MemWrite, o_IRWrite, o_MemtoReg_2, o_RegDst_2, o_RegWrite,
           o_ALUSrcA, o_ALUSrcB_2, o_PCSource_2, o_ALUOp_3, o_Retired,
           o_InstrCount, o_Trap, o_TrapCause_2, o_State_4
  );
endinterface

// File: rtl/mips_mem_wait_timer.sv
// Counts cycles spent waiting for memory in the current memory state and
// flags a timeout in the cycle the wait limit is reached without ready.
// Ready arriving in that same cycle wins over the timeout.
module mips_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,   // entering a memory state next cycle
  input  logic i_active,  // currently in a memory state
  input  logic i_ready,   // memory completes this cycle
  output logic o_timeout
);

  localparam int W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT - 1);

  logic [W-1:0] r_count;

  // Wait-cycle counter: cleared on entry, advances on each unready cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_active && !i_ready && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_timeout = i_active && !i_ready && (r_count == LIMIT);

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS sequencer: steps each instruction through
// FETCH/DECODE/EXECUTE/MEM/WB, drives the datapath selects as registered
// Moore outputs, counts retired instructions and traps on illegal opcodes
// or memory timeouts.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  mips_multicycle_control_if.master bus
);

  state_e           r_state;
  ctrl_t            r_ctrl;
  logic [CNT_W-1:0] r_count;
  logic             r_trap;
  logic [1:0]       r_cause;

  state_e           w_next_state;
  logic [1:0]       w_cause;
  logic             w_mem_state;
  logic             w_next_mem;
  logic             w_mem_enter;
  logic             w_timeout;
  logic             w_fetch_done;
  logic             w_retire;

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_READ) ||
                       (r_state == S_MEM_WRITE);
  assign w_next_mem  = (w_next_state == S_FETCH) || (w_next_state == S_MEM_READ) ||
                       (w_next_state == S_MEM_WRITE);
  assign w_mem_enter = w_next_mem && (w_next_state != r_state);

  mips_mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_mem_enter),
    .i_active (w_mem_state),
    .i_ready  (bus.in_MemReady),
    .o_timeout(w_timeout)
  );

  // Next-state selection and the trap cause recorded on entry to TRAP
  always_comb begin
    w_next_state = r_state;
    w_cause      = TRAP_NONE;
    case (r_state)
      S_FETCH: begin
        if (bus.in_MemReady) begin
          w_next_state = S_DECODE;
        end else if (w_timeout) begin
          w_next_state = S_TRAP;
          w_cause      = TRAP_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (bus.in_OP_6)
          OP_RTYPE:                         w_next_state = S_EXEC_R;
          OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: w_next_state = S_EXEC_I;
          OP_LW, OP_SW:                     w_next_state = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                   w_next_state = S_BRANCH;
          OP_J, OP_JAL:                     w_next_state = S_JUMP;
          default: begin
            w_next_state = S_TRAP;
            w_cause      = TRAP_ILLEGAL;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I: w_next_state = S_ALU_WB;
      S_MEM_ADDR:
        w_next_state = (bus.in_OP_6 == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: begin
        if (bus.in_MemReady) begin
          w_next_state = S_MEM_WB;
        end else if (w_timeout) begin
          w_next_state = S_TRAP;
          w_cause      = TRAP_TIMEOUT;
        end
      end
      S_MEM_WRITE: begin
        if (bus.in_MemReady) begin
          w_next_state = S_FETCH;
        end else if (w_timeout) begin
          w_next_state = S_TRAP;
          w_cause      = TRAP_TIMEOUT;
        end
      end
      S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP: w_next_state = S_FETCH;
      S_TRAP:  w_next_state = S_TRAP;
      default: w_next_state = S_FETCH;
    endcase
  end

  // The fetch strobes and the store retire fire in the completing cycle,
  // so they are qualified by in_MemReady rather than registered.
  assign w_fetch_done = (r_state == S_FETCH) && bus.in_MemReady;
  assign w_retire     = r_ctrl.retire ||
                        ((r_state == S_MEM_WRITE) && bus.in_MemReady);

  // Sequencer: state, registered control word, retire counter, trap flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_ctrl  <= ctrl_decode(S_FETCH, OP_RTYPE, 1'b0);
      r_count <= '0;
      r_trap  <= 1'b0;
      r_cause <= TRAP_NONE;
    end else begin
      r_state <= w_next_state;
      r_ctrl  <= ctrl_decode(w_next_state, bus.in_OP_6, r_state == S_EXEC_R);
      if (w_retire) begin
        r_count <= r_count + 1'b1;
      end
      if ((w_next_state == S_TRAP) && (r_state != S_TRAP)) begin
        r_trap  <= 1'b1;
        r_cause <= w_cause;
      end
    end
  end

  assign bus.o_PCWrite     = r_ctrl.pc_write || w_fetch_done;
  assign bus.o_PCWriteCond = r_ctrl.pc_write_cond;
  assign bus.o_BranchType  = r_ctrl.branch_type;
  assign bus.o_IorD        = r_ctrl.iord;
  assign bus.o_MemRead     = r_ctrl.mem_read;
  assign bus.o_MemWrite    = r_ctrl.mem_write;
  assign bus.o_IRWrite     = w_fetch_done;
  assign bus.o_MemtoReg_2  = r_ctrl.mem_to_reg;
  assign bus.o_RegDst_2    = r_ctrl.reg_dst;
  assign bus.o_RegWrite    = r_ctrl.reg_write;
  assign bus.o_ALUSrcA     = r_ctrl.alu_src_a;
  assign bus.o_ALUSrcB_2   = r_ctrl.alu_src_b;
  assign bus.o_PCSource_2  = r_ctrl.pc_source;
  assign bus.o_ALUOp_3     = r_ctrl.alu_op;
  assign bus.o_Retired     = w_retire;
  assign bus.o_InstrCount  = r_count;
  assign bus.o_Trap        = r_trap;
  assign bus.o_TrapCause_2 = r_cause;
  assign bus.o_State_4     = r_state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for the multi-cycle sequencer. A reference model expands each
// instruction into its expected per-cycle control observations; a driver
// replays the matching per-cycle inputs and a monitor compares every cycle.
module tb_mips_multicycle_control;

  localparam int TMO = 4;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03,
                         OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08,
                         OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_LUI = 6'h0F,
                         OP_LW = 6'h23, OP_SW = 6'h2B;

  localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_EXEC_R = 4'd2,
                         ST_EXEC_I = 4'd3, ST_ALU_WB = 4'd4, ST_MEM_ADDR = 4'd5,
                         ST_MEM_READ = 4'd6, ST_MEM_WB = 4'd7, ST_MEM_WRITE = 4'd8,
                         ST_BRANCH = 4'd9, ST_JUMP = 4'd10, ST_TRAP = 4'd11;

  typedef struct packed {
    logic [3:0]  st;
    logic        pcw, pcwc, bt, iord, mr, mw, irw;
    logic [1:0]  m2r, rdst;
    logic        rw, sa;
    logic [1:0]  sb, psrc;
    logic [2:0]  aop;
    logic        ret, trap;
    logic [1:0]  cause;
    logic [31:0] cnt;
  } obs_t;
  localparam int OBS_W = $bits(obs_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_multicycle_control_if #(.CNT_W(32)) bus();

  mips_multicycle_control #(
    .MEM_TIMEOUT(TMO),
    .CNT_W      (32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [OBS_W-1:0] exp_q[$];
  logic [7:0]       stim_q[$];   // {reset, opcode, ready} per cycle
  int               n_total = 0;
  int               n_bad   = 0;
  int               step    = 0;

  // reference model state
  logic [31:0] m_cnt     = '0;
  logic        m_trapped = 1'b0;
  logic [1:0]  m_cause   = 2'b00;

  function automatic logic [5:0] rnd_op();
    return 6'($urandom);
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI,
                      OP_ORI, OP_LUI, OP_LW, OP_SW};
  endfunction

  function automatic obs_t blank(input logic [3:0] st);
    obs_t o;
    o = '0;
    o.st    = st;
    o.cnt   = m_cnt;
    o.trap  = m_trapped;
    o.cause = m_cause;
    return o;
  endfunction

  // Outputs of a memory-waiting state (fetch, load, store)
  function automatic obs_t mem_obs(input logic [3:0] st);
    obs_t o;
    o = blank(st);
    case (st)
      ST_FETCH:    begin o.mr = 1'b1; o.sb = 2'b01; o.aop = 3'b011; end
      ST_MEM_READ: begin o.mr = 1'b1; o.iord = 1'b1; end
      default:     begin o.mw = 1'b1; o.iord = 1'b1; end
    endcase
    return o;
  endfunction

  // ---------------- driver tasks (stimulus + expectation) ----------------
  task automatic push(input obs_t o, input logic rst, input logic [5:0] op,
                      input logic rdy);
    exp_q.push_back(o);
    stim_q.push_back({rst, op, rdy});
  endtask

  task automatic push_retire(input obs_t o, input logic [5:0] op);
    o.ret = 1'b1;
    push(o, 1'b0, op, 1'($urandom));
    m_cnt = m_cnt + 1;
  endtask

  task automatic reset_cycles(input int n);
    m_cnt     = '0;
    m_trapped = 1'b0;
    m_cause   = 2'b00;
    for (int k = 0; k < n; k++) push(mem_obs(ST_FETCH), 1'b1, rnd_op(), 1'b0);
  endtask

  task automatic trap_hold(input int n);
    for (int k = 0; k < n; k++) push(blank(ST_TRAP), 1'b0, rnd_op(), 1'($urandom));
  endtask

  // Wait 'waits' unready cycles in a memory state, then complete it
  task automatic mem_phase(input logic [3:0] st, input logic [5:0] op,
                           input int waits, output bit ok);
    obs_t o;
    o = mem_obs(st);
    for (int k = 0; k < waits && k < TMO; k++)
      push(o, 1'b0, (st == ST_FETCH) ? rnd_op() : op, 1'b0);
    if (waits >= TMO) begin
      m_trapped = 1'b1;
      m_cause   = 2'b10;
      ok        = 1'b0;
    end else begin
      if (st == ST_FETCH) begin
        o.irw = 1'b1;
        o.pcw = 1'b1;
        push(o, 1'b0, rnd_op(), 1'b1);
      end else if (st == ST_MEM_WRITE) begin
        o.ret = 1'b1;
        push(o, 1'b0, op, 1'b1);
        m_cnt = m_cnt + 1;
      end else begin
        push(o, 1'b0, op, 1'b1);
      end
      ok = 1'b1;
    end
  endtask

  task automatic push_decode(input logic [5:0] op);
    obs_t o;
    o = blank(ST_DECODE);
    o.sb = 2'b11; o.aop = 3'b011;
    push(o, 1'b0, op, 1'($urandom));
  endtask

  task automatic push_mem_addr(input logic [5:0] op);
    obs_t o;
    o = blank(ST_MEM_ADDR);
    o.sa = 1'b1; o.sb = 2'b10; o.aop = 3'b011;
    push(o, 1'b0, op, 1'($urandom));
  endtask

  // Reference model: one instruction, wf fetch waits, wm data-memory waits
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
    obs_t o;
    bit   ok;
    mem_phase(ST_FETCH, op, wf, ok);
    if (!ok) return;
    push_decode(op);
    if (op == OP_R) begin
      o = blank(ST_EXEC_R); o.sa = 1'b1; o.sb = 2'b00; o.aop = 3'b111;
      push(o, 1'b0, op, 1'($urandom));
      o = blank(ST_ALU_WB); o.rw = 1'b1; o.rdst = 2'b01;
      push_retire(o, op);
    end else if (op inside {OP_ADDI, OP_ORI, OP_ANDI, OP_LUI}) begin
      o = blank(ST_EXEC_I); o.sa = 1'b1; o.sb = 2'b10;
      case (op)
        OP_ADDI: o.aop = 3'b100;
        OP_ORI:  o.aop = 3'b101;
        OP_ANDI: o.aop = 3'b110;
        default: o.aop = 3'b000;
      endcase
      push(o, 1'b0, op, 1'($urandom));
      o = blank(ST_ALU_WB); o.rw = 1'b1; o.rdst = 2'b00;
      push_retire(o, op);
    end else if (op == OP_LW || op == OP_SW) begin
      push_mem_addr(op);
      mem_phase((op == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE, op, wm, ok);
      if (ok && op == OP_LW) begin
        o = blank(ST_MEM_WB); o.rw = 1'b1; o.m2r = 2'b01;
        push_retire(o, op);
      end
    end else if (op == OP_BEQ || op == OP_BNE) begin
      o = blank(ST_BRANCH); o.sa = 1'b1; o.sb = 2'b00; o.aop = 3'b001;
      o.pcwc = 1'b1; o.psrc = 2'b01; o.bt = (op == OP_BEQ);
      push_retire(o, op);
    end else if (op == OP_J || op == OP_JAL) begin
      o = blank(ST_JUMP); o.pcw = 1'b1; o.psrc = 2'b10; o.aop = 3'b010;
      if (op == OP_JAL) begin o.rw = 1'b1; o.rdst = 2'b10; o.m2r = 2'b10; end
      push_retire(o, op);
    end else begin
      m_trapped = 1'b1;
      m_cause   = 2'b01;
    end
  endtask

  // Store cut short by reset while its write is still pending
  task automatic sw_cut();
    bit ok;
    mem_phase(ST_FETCH, OP_SW, 0, ok);
    push_decode(OP_SW);
    push_mem_addr(OP_SW);
    push(mem_obs(ST_MEM_WRITE), 1'b0, OP_SW, 1'b0);
    push(mem_obs(ST_MEM_WRITE), 1'b0, OP_SW, 1'b0);
    reset_cycles(2);
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.st    = bus.o_State_4;
    o.pcw   = bus.o_PCWrite;
    o.pcwc  = bus.o_PCWriteCond;
    o.bt    = bus.o_BranchType;
    o.iord  = bus.o_IorD;
    o.mr    = bus.o_MemRead;
    o.mw    = bus.o_MemWrite;
    o.irw   = bus.o_IRWrite;
    o.m2r   = bus.o_MemtoReg_2;
    o.rdst  = bus.o_RegDst_2;
    o.rw    = bus.o_RegWrite;
    o.sa    = bus.o_ALUSrcA;
    o.sb    = bus.o_ALUSrcB_2;
    o.psrc  = bus.o_PCSource_2;
    o.aop   = bus.o_ALUOp_3;
    o.ret   = bus.o_Retired;
    o.trap  = bus.o_Trap;
    o.cause = bus.o_TrapCause_2;
    o.cnt   = bus.o_InstrCount;
    return o;
  endfunction

  // Input driver: one stimulus word per cycle, applied after the falling edge
  initial begin
    logic [7:0] s;
    forever begin
      @(negedge clk);
      #1;
      if (stim_q.size() > 0) begin
        s = stim_q.pop_front();
        reset           = s[7];
        bus.in_OP_6     = s[6:1];
        bus.in_MemReady = s[0];
      end
    end
  end

  // Monitor: compares every cycle for which an expectation is queued
  initial begin
    obs_t got, want;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        want = obs_t'(exp_q.pop_front());
        got  = sample();
        n_total++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL step%0d ctrl: state got=%0d want=%0d word got=%h want=%h",
                   step, got.st, want.st, got, want);
        end
        step++;
      end
    end
  end

  // Stimulus program and final report
  initial begin
    logic [5:0] legal[11];
    logic [5:0] op;
    int         bound;
    legal = '{OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI,
              OP_ORI, OP_LUI, OP_LW, OP_SW};
    reset           = 1'b1;
    bus.in_OP_6     = 6'h00;
    bus.in_MemReady = 1'b0;

    reset_cycles(3);
    run_instr(OP_R,    0, 0);
    run_instr(OP_LW,   0, 3);
    run_instr(OP_BNE,  0, 0);
    run_instr(OP_JAL,  0, 0);
    run_instr(OP_ADDI, 1, 0);
    run_instr(OP_ORI,  0, 0);
    run_instr(OP_ANDI, 2, 0);
    run_instr(OP_LUI,  0, 0);
    run_instr(OP_BEQ,  TMO - 1, 0);   // fetch ready exactly at the limit
    run_instr(OP_J,    0, 0);
    run_instr(OP_SW,   0, 2);
    run_instr(OP_SW,   0, TMO - 1);   // store ready exactly at the limit
    run_instr(OP_LW,   0, TMO - 1);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        do op = rnd_op(); while (is_legal(op));
      end else begin
        op = legal[$urandom_range(0, 10)];
      end
      run_instr(op, $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1));
      if (m_trapped) begin
        trap_hold(3);
        reset_cycles(1);
      end
    end

    run_instr(6'h3F, 0, 0);           // illegal opcode
    trap_hold(20);
    reset_cycles(2);
    run_instr(OP_R, 0, 0);
    run_instr(OP_ADDI, TMO, 0);       // fetch timeout
    trap_hold(5);
    reset_cycles(1);
    run_instr(OP_LW, 0, TMO);         // load timeout
    trap_hold(3);
    reset_cycles(1);
    run_instr(OP_SW, 0, TMO);         // store timeout
    trap_hold(3);
    reset_cycles(1);
    run_instr(OP_ORI, 0, 0);
    run_instr(OP_R, 0, 0);
    sw_cut();                         // reset while store pending
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_JAL, 0, 0);

    bound = stim_q.size() + 20;
    for (int i = 0; i < bound && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #4;
    end
    if (exp_q.size() != 0) begin
      n_total++;
      n_bad++;
      $display("FAIL drain: pending got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
